// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit
//   Sequential 32-bit multiply / divide unit (MIPS MULT/MULTU/DIV/DIVU style).
//   One radix-2 iteration per clock, fixed latency of WIDTH+1 cycles from the
//   accepting edge to the hi/lo write.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          request an operation (sampled only in IDLE)
//   mul0_div1_sel  0 = multiply, 1 = divide
//   signed_op      1 = signed, 0 = unsigned
//   in_a / in_b    multiplicand/dividend, multiplier/divisor
//   flush          synchronous abort of the operation in flight
//   busy           operation accepted and not yet written
//   done           one-cycle pulse, hi/lo just updated
//   hi / lo        registered result (product high/low, remainder/quotient)
//   div_by_zero    pulses with done when a divide had in_b == 0
module muldiv_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mul0_div1_sel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      LAST = CW'(WIDTH-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op_div;
    logic             r_neg_res;   // product / quotient must be negated
    logic             r_neg_a;     // dividend was negative (remainder sign)
    logic             r_div0;
    logic [WIDTH-1:0] r_b_mag;
    logic [WIDTH-1:0] r_acc_hi;    // partial product high / partial remainder
    logic [WIDTH-1:0] r_acc_lo;    // multiplier bits / dividend-then-quotient bits

    // Operand magnitudes at issue
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_a_neg = signed_op & in_a[WIDTH-1];
    assign w_b_neg = signed_op & in_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~in_a + ONE) : in_a;
    assign w_b_mag = w_b_neg ? (~in_b + ONE) : in_b;

    // Multiply step: conditionally add, then shift {sum, acc_lo} right by one
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});

    // Restoring divide step: shift in next dividend bit, trial subtract.
    // The shifted remainder fits in WIDTH+1 bits, so bit WIDTH of the
    // difference is the borrow.
    logic [WIDTH:0] w_shift, w_diff;
    logic           w_q_bit;
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b_mag};
    assign w_q_bit = ~w_diff[WIDTH];

    // Sign correction
    logic [2*WIDTH-1:0] w_prod, w_prod_n;
    logic [WIDTH-1:0]   w_quo_n, w_rem_n;
    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_prod_n = ~w_prod + ONE2;
    assign w_quo_n  = ~r_acc_lo + ONE;
    assign w_rem_n  = ~r_acc_hi + ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_div    <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_a     <= 1'b0;
            r_div0      <= 1'b0;
            r_b_mag     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // flush beats start
                    if (start && !flush) begin
                        r_op_div  <= mul0_div1_sel;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_a   <= w_a_neg;
                        r_div0    <= mul0_div1_sel && (in_b == '0);
                        r_b_mag   <= w_b_mag;
                        r_acc_hi  <= '0;
                        r_acc_lo  <= w_a_mag;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_op_div) begin
                            r_acc_hi <= w_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_q_bit};
                        end else begin
                            r_acc_hi <= w_mul_sum[WIDTH:1];
                            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST)
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (r_op_div) begin
                            // With a zero divisor the restoring loop leaves an
                            // all-ones quotient and |a| as remainder; restoring
                            // the dividend sign on the remainder yields in_a.
                            lo <= r_div0 ? {WIDTH{1'b1}} : (r_neg_res ? w_quo_n : r_acc_lo);
                            hi <= r_neg_a ? w_rem_n : r_acc_hi;
                            div_by_zero <= r_div0;
                        end else begin
                            {hi, lo} <= r_neg_res ? w_prod_n : w_prod;
                        end
                        done <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
module tb_muldiv_seq_unit;
    localparam int W = 32;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, sel = 1'b0, sgn = 1'b0, flush = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    muldiv_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mul0_div1_sel(sel), .signed_op(sgn),
        .in_a(a), .in_b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(dz)
    );

    // Reference result {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [2*W:0] ref_calc(input logic div, input logic s,
                                              input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        logic [2*W-1:0] p;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end
        if (!div) begin
            p = sx * sy;
            return {1'b0, p};
        end
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        return {1'b0, W'(sx % sy), W'(sx / sy)};
    endfunction

    // Transaction-level model: accept, count down the fixed latency, publish.
    logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_busy) begin
                if (flush) m_busy = 1'b0;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_done = 1'b1;
                        m_dz = p_dz; m_hi = p_hi; m_lo = p_lo;
                    end
                end
            end else if (start && !flush) begin
                {p_dz, p_hi, p_lo} = ref_calc(sel, sgn, a, b);
                m_busy = 1'b1;
                m_left = W + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle compare against the model
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("div_by_zero", 64'(dz), 64'(m_dz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    end

    task automatic drive_start(input logic op, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; sel = op; sgn = s; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic issue(input logic op, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #2;
        drive_start(op, s, x, y);
    endtask

    // Waits for done (bounded), checks latency and hand-computed result.
    task automatic wait_done(input string nm, input int exp_n,
                             input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int  n = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin n = i; seen = 1'b1; break; end
        end
        chk({nm, " latency"}, 64'(n), 64'(exp_n));
        if (seen) begin
            chk({nm, " hi"}, 64'(hi), 64'(eh));
            chk({nm, " lo"}, 64'(lo), 64'(el));
            chk({nm, " dz"}, 64'(dz), 64'(ed));
        end
    endtask

    initial begin
        int cnt;
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi",   64'(hi),   64'd0);
        chk("reset lo",   64'(lo),   64'd0);
        chk("reset dz",   64'(dz),   64'd0);
        @(posedge clk); #2;
        rst = 1'b1;

        // first start right after reset release is accepted
        drive_start(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_done("smul -3*5", 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("umul max", 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("smul -1*-1", 34, 32'h0, 32'h1, 1'b0);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("sdiv -7/2", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        wait_done("udiv 100/7", 34, 32'd2, 32'd14, 1'b0);
        issue(1'b1, 1'b0, 32'd100, 32'd0);
        wait_done("div 100/0", 34, 32'h64, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        chk("dz one cycle", 64'(dz), 64'd0);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("sdiv overflow", 34, 32'h0, 32'h8000_0000, 1'b0);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("udiv big", 34, 32'h8000_0000, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0);
        wait_done("sdiv -7/0", 34, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        issue(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done("sdiv 7/-2", 34, 32'd1, 32'hFFFF_FFFD, 1'b0);

        // flush mid-operation: busy drops, hi/lo untouched
        issue(1'b0, 1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush hi", 64'(hi), 64'd1);
        chk("flush lo", 64'(lo), 64'hFFFF_FFFD);
        @(posedge clk); #2;
        drive_start(1'b0, 1'b0, 32'd6, 32'd7);
        wait_done("after flush", 34, 32'd0, 32'd42, 1'b0);

        // flush and start together in IDLE: nothing accepted
        @(posedge clk); #2;
        flush = 1'b1;
        drive_start(1'b0, 1'b0, 32'd9, 32'd9);
        flush = 1'b0;
        @(negedge clk);
        chk("flush+start busy", 64'(busy), 64'd0);

        // ignored start while busy, then back-to-back start in the done cycle
        issue(1'b0, 1'b0, 32'd3, 32'd4);
        repeat (3) @(posedge clk);
        #2 drive_start(1'b0, 1'b0, 32'd100, 32'd100);
        wait_done("b2b first", 30, 32'd0, 32'd12, 1'b0);
        drive_start(1'b1, 1'b0, 32'd50, 32'd5);
        wait_done("b2b second", 34, 32'd0, 32'd10, 1'b0);

        // asynchronous reset mid-operation
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        repeat (13) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst done", 64'(done), 64'd0);
        chk("arst hi",   64'(hi),   64'd0);
        chk("arst lo",   64'(lo),   64'd0);
        chk("arst dz",   64'(dz),   64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no done after reset", 64'(cnt), 64'd0);
        issue(1'b0, 1'b0, 32'd10, 32'd10);
        wait_done("post reset", 34, 32'd0, 32'd100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
